// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: one WIDTH-bit AND/OR/ADD/SUB/SLT op evaluated LSB-first, one bit per clock.
// Optional build macro ALU_SLT_OVF_FIX_EN: SLT uses set ^ overflow (signed-correct) instead of raw sign.
module alu_serial_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state, state_nxt;
  logic             accept, last;
  logic [WIDTH-1:0] a_sh, b_sh, result_sh;
  logic [2:0]       op_q;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             abit, bbit, g, p, s, c, sel, less, arith;
  logic [WIDTH-1:0] res_fin;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state; start is only honoured in IDLE and DONE
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
          accept    = 1'b1;
        end
      end
      S_RUN: begin
        if (cnt == CW'(WIDTH - 1)) begin
          state_nxt = S_DONE;
          last      = 1'b1;
        end
      end
      S_DONE: begin
        if (start) begin
          state_nxt = S_RUN;
          accept    = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // 1-bit ALU slice plus the values that finalise the op on the MSB step
  always_comb begin
    abit  = a_sh[0];
    bbit  = b_sh[0] ^ op_q[2];
    g     = abit & bbit;
    p     = abit | bbit;
    s     = abit ^ bbit ^ carry;
    c     = (abit & bbit) | (abit & carry) | (bbit & carry);
    arith = op_q[1];
    sel   = s;
    case (op_q[1:0])
      2'b00:   sel = g;
      2'b01:   sel = p;
      default: sel = s;
    endcase
`ifdef ALU_SLT_OVF_FIX_EN
    less = s ^ (carry ^ c);
`else
    less = s;
`endif
    res_fin = {sel, result_sh[WIDTH-1:1]};
    if (op_q[1:0] == 2'b11) res_fin = WIDTH'(less);
  end

  // Datapath: operand shifters, carry flop, bit counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      result_sh <= '0;
      op_q      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b1;
    end else begin
      busy <= (state_nxt == S_RUN);
      done <= last;
      if (accept) begin
        a_sh  <= a;
        b_sh  <= b;
        op_q  <= op;
        carry <= op[2];
        cnt   <= '0;
      end else if (state == S_RUN) begin
        result_sh <= {sel, result_sh[WIDTH-1:1]};
        carry     <= c;
        a_sh      <= a_sh >> 1;
        b_sh      <= b_sh >> 1;
        cnt       <= cnt + CW'(1);
        if (last) begin
          result   <= res_fin;
          cout     <= arith & c;
          overflow <= arith & (carry ^ c);
          zero     <= (res_fin == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Randomized self-checking bench for alu_serial_seq (WIDTH = 8) against an arithmetic reference model.
module tb_alu_serial_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic [2:0] op;
  logic       busy, done, cout, overflow, zero;
  logic [7:0] result;

  int n_vec = 0;
  int n_bad = 0;
  int clk_cnt = 0;

  alu_serial_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .op(op),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) clk_cnt <= clk_cnt + 1;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got hang expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {overflow, cout, result} from two's-complement arithmetic
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic [2:0] o);
    logic [7:0] yy;
    logic [8:0] sum;
    logic       ovf, set, lt;
    logic [7:0] res;
    yy  = o[2] ? ~y : y;
    sum = {1'b0, x} + {1'b0, yy} + 9'(o[2]);
    ovf = (x[7] == yy[7]) && (sum[7] != x[7]);
    set = sum[7];
`ifdef ALU_SLT_OVF_FIX_EN
    lt = set ^ ovf;
`else
    lt = set;
`endif
    case (o[1:0])
      2'b00:   res = x & yy;
      2'b01:   res = x | yy;
      2'b10:   res = sum[7:0];
      default: res = {7'd0, lt};
    endcase
    if (o[1]) return {ovf, sum[8], res};
    return {2'b00, res};
  endfunction

  task automatic scramble();
    a  = 8'($urandom);
    b  = 8'($urandom);
    op = 3'($urandom);
  endtask

  // Issue one op from IDLE; optionally pulse a stray start at RUN cycle inj
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] top, input int inj);
    logic [9:0] exp;
    int cyc, busy_cyc, extra;
    bit seen;
    exp = model(ta, tb, top);
    a = ta; b = tb; op = top; start = 1'b1;
    cyc = 0; busy_cyc = 0; seen = 0;
    while (!seen && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        scramble();
      end
      if (inj != 0 && cyc == inj) begin
        start = 1'b1;
        scramble();
      end else if (inj != 0 && cyc == inj + 1) begin
        start = 1'b0;
      end
      if (done) seen = 1;
      else if (busy) busy_cyc++;
    end
    check("latency", 32'(cyc), 32'd9);
    check("busy_cycles", 32'(busy_cyc), 32'd8);
    check("result", 32'(result), 32'(exp[7:0]));
    check("cout", 32'(cout), 32'(exp[8]));
    check("overflow", 32'(overflow), 32'(exp[9]));
    check("zero", 32'(zero), 32'(exp[7:0] == 8'd0));
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("result_hold", 32'(result), 32'(exp[7:0]));
    if (inj != 0) begin
      extra = 0;
      repeat (12) begin
        @(negedge clk);
        if (done) extra++;
      end
      check("stray_done", 32'(extra), 32'd0);
      check("stray_result", 32'(result), 32'(exp[7:0]));
    end
  endtask

  initial begin
    logic [2:0] lops [3];
    logic [9:0] exp;
    int t_prev, extra, busy_seen;
    bit seen;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; op = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'({cout, overflow, zero}), 32'b001);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed corner cases
    run_op(8'h7F, 8'h01, 3'b010, 0);
    run_op(8'h05, 8'h05, 3'b110, 0);
    run_op(8'h80, 8'h01, 3'b111, 0);
    run_op(8'h02, 8'h03, 3'b111, 0);
    run_op(8'h00, 8'h00, 3'b010, 0);
    run_op(8'hFF, 8'h01, 3'b010, 0);

    // Back-to-back logic ops with start held through DONE
    lops[0] = 3'b000; lops[1] = 3'b001; lops[2] = 3'b100;
    a = 8'hF0; b = 8'h3C; op = lops[0]; start = 1'b1;
    t_prev = clk_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i < 2) op = lops[i+1];
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
        if (done) seen = 1;
        else @(negedge clk);
      end
      exp = model(8'hF0, 8'h3C, lops[i]);
      check("b2b_result", 32'(result), 32'(exp[7:0]));
      check("b2b_period", 32'(clk_cnt - t_prev), 32'd9);
      t_prev = clk_cnt;
      if (i == 2) start = 1'b0;
    end
    @(negedge clk);
    check("b2b_idle", 32'({busy, done}), 32'd0);

    // Stray start during RUN is ignored
    run_op(8'h12, 8'h34, 3'b010, 3);

    // Reset asserted mid-run
    a = 8'h7F; b = 8'h01; op = 3'b010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_flags", 32'({done, cout, overflow, zero}), 32'b0001);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0; busy_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) extra++;
      if (busy) busy_seen++;
    end
    check("mid_rst_no_done", 32'(extra), 32'd0);
    check("mid_rst_idle", 32'(busy_seen), 32'd0);
    run_op(8'h05, 8'h05, 3'b110, 0);

    // Random ops over all opcodes
    for (int i = 0; i < 40; i++)
      run_op(8'($urandom), 8'($urandom), 3'($urandom), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
